// File: rtl/settle_scheduler.sv
// Half-cycle settle sequencer: toggles the emulated phi pad, then relaxes the
// node network until quiet or out of budget. `SETTLE_STATS_EN adds step statistics.
module settle_scheduler #(
   parameter int W        = 16,
   parameter int ITER_W   = 10,
   parameter int MAX_ITER = 1000,
   parameter int QUIET    = 4,
   parameter int THRESH   = 2
) (
   input  logic              eclk,
   input  logic              erst_n,
   input  logic              step_req,
   input  logic [W-1:0]      i_max,
   input  logic              iter_valid,
   output logic              iter_go,
   output logic              phi,
   output logic              busy,
   output logic              step_done,
   output logic              sample,
   output logic              timeout,
   output logic [ITER_W-1:0] iter_count
`ifdef SETTLE_STATS_EN
  ,output logic [ITER_W-1:0] iter_peak,
   output logic [31:0]       step_total
`endif
);

   localparam int QW = (QUIET < 2) ? 1 : $clog2(QUIET + 1);

   localparam logic [W-1:0]      THRESH_V = W'(THRESH);
   localparam logic [QW-1:0]     QUIET_V  = QW'(QUIET);
   localparam logic [ITER_W-1:0] MAX_V    = ITER_W'(MAX_ITER);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TOGGLE,
      S_LAUNCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state;
   logic [ITER_W-1:0] iter_cnt;
   logic [QW-1:0]     quiet_cnt;
   logic [QW-1:0]     quiet_next;

   // Quiet run length after folding in the iteration that just completed.
   always_comb begin
      quiet_next = '0;
      if (i_max <= THRESH_V) begin
         if (quiet_cnt == QUIET_V) quiet_next = quiet_cnt;
         else                      quiet_next = quiet_cnt + QW'(1);
      end
   end

   always_ff @(posedge eclk or negedge erst_n) begin
      if (!erst_n) begin
         state      <= S_IDLE;
         iter_cnt   <= '0;
         quiet_cnt  <= '0;
         iter_go    <= 1'b0;
         phi        <= 1'b0;
         busy       <= 1'b0;
         step_done  <= 1'b0;
         sample     <= 1'b0;
         timeout    <= 1'b0;
         iter_count <= '0;
      end else begin
         iter_go   <= 1'b0;
         step_done <= 1'b0;
         sample    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (step_req) begin
                  state     <= S_TOGGLE;
                  phi       <= ~phi;
                  iter_cnt  <= '0;
                  quiet_cnt <= '0;
                  busy      <= 1'b1;
               end
            end
            S_TOGGLE: begin
               state   <= S_LAUNCH;
               iter_go <= 1'b1;
            end
            S_LAUNCH: begin
               iter_cnt <= iter_cnt + ITER_W'(1);
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (iter_valid) begin
                  quiet_cnt <= quiet_next;
                  // Settling is tested first so it wins over budget exhaustion.
                  if (quiet_next == QUIET_V) begin
                     state     <= S_DONE;
                     step_done <= 1'b1;
                     sample    <= 1'b1;
                  end else if (iter_cnt == MAX_V) begin
                     state     <= S_DONE;
                     step_done <= 1'b1;
                     sample    <= 1'b1;
                     timeout   <= 1'b1;
                  end else begin
                     state   <= S_LAUNCH;
                     iter_go <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               iter_count <= iter_cnt;
               state      <= S_IDLE;
               busy       <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SETTLE_STATS_EN
   always_ff @(posedge eclk or negedge erst_n) begin
      if (!erst_n) begin
         iter_peak  <= '0;
         step_total <= '0;
      end else if (state == S_DONE) begin
         if (iter_cnt > iter_peak) iter_peak <= iter_cnt;
         step_total <= step_total + 32'd1;
      end
   end
`endif

endmodule
